muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for step_ex; owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs an iterative divider and a latency-padded multiplier.
- Drives the EX stage's stall_for_mul_cycle until the result is committed; exposes HI/LO for MFHI/MFLO.

---
 rtl/muldiv_ctrl_pkg.sv | 37 +++
 rtl/muldiv_ctrl_div_iter.sv | 55 +++++
 rtl/muldiv_ctrl.sv | 166 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared op-codes, FSM state encoding and decode helpers for the muldiv sequencer.
// MULDIV_MADD_EN adds op 7 (MADD) to the multiply class.
package muldiv_ctrl_pkg;

    localparam logic [2:0] MULDIV_OP_NONE  = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULT  = 3'd1;
    localparam logic [2:0] MULDIV_OP_MULTU = 3'd2;
    localparam logic [2:0] MULDIV_OP_DIV   = 3'd3;
    localparam logic [2:0] MULDIV_OP_DIVU  = 3'd4;
    localparam logic [2:0] MULDIV_OP_MTHI  = 3'd5;
    localparam logic [2:0] MULDIV_OP_MTLO  = 3'd6;
    localparam logic [2:0] MULDIV_OP_MADD  = 3'd7;

    typedef enum logic [1:0] {
        MULDIV_ST_IDLE = 2'd0,
        MULDIV_ST_MUL  = 2'd1,
        MULDIV_ST_DIV  = 2'd2,
        MULDIV_ST_DONE = 2'd3
    } muldiv_st_t;

    function automatic logic is_mul_op(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
        return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_MULTU) || (op == MULDIV_OP_MADD);
`else
        return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// 32-bit unsigned restoring divider, one quotient bit per step.
// o_done is high during the final step, so results are valid the following cycle.
module muldiv_ctrl_div_iter #(
    parameter int DIV_ITER = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_done
);

    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // Quotient register doubles as the dividend shift-out register.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_quo <= 32'd0;
            r_rem <= 32'd0;
            r_dvs <= 32'd0;
            r_cnt <= 6'd0;
        end else if (i_load) begin
            r_quo <= i_dividend;
            r_rem <= 32'd0;
            r_dvs <= i_divisor;
            r_cnt <= 6'd0;
        end else if (i_step) begin
            if (!w_diff[32]) begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= w_shift[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end
            r_cnt <= r_cnt + 6'd1;
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_done      = i_step && (r_cnt == 6'(DIV_ITER - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; stalls EX until commit.
// Optional MULDIV_MADD_EN enables op 7 (signed multiply-accumulate into HI:LO).
//
// state | meaning
// IDLE  | waiting for a muldiv-class op from EX; MTHI/MTLO write here
// MUL   | latency padding for the multiplier
// DIV   | one restoring-divide step per cycle
// DONE  | sign fixup and HI/LO commit; stall released
import muldiv_ctrl_pkg::*;

module muldiv_ctrl #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    muldiv_st_t  r_state;
    logic [5:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_dz;
    logic        r_q_neg;
    logic        r_r_neg;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_div_signed;
    logic        w_div_load;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_div_quo;
    logic [31:0] w_div_rem;
    logic        w_div_done;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_mul_signed;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;

    assign w_div_signed = (i_op == MULDIV_OP_DIV);
    assign w_dvd        = w_div_signed ? abs32(i_op_a) : i_op_a;
    assign w_dvs        = w_div_signed ? abs32(i_op_b) : i_op_b;
    assign w_div_load   = !i_flush && i_start && (r_state == MULDIV_ST_IDLE)
                          && is_div_op(i_op) && (i_op_b != 32'd0);

    muldiv_ctrl_div_iter #(.DIV_ITER(DIV_ITER)) u_div (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_div_load),
        .i_step      (r_state == MULDIV_ST_DIV),
        .i_dividend  (w_dvd),
        .i_divisor   (w_dvs),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem),
        .o_done      (w_div_done)
    );

    assign w_quo_fix = r_q_neg ? (~w_div_quo + 32'd1) : w_div_quo;
    assign w_rem_fix = r_r_neg ? (~w_div_rem + 32'd1) : w_div_rem;

    // Sign-extend to 64 bits so one truncated multiply serves signed and unsigned.
    assign w_mul_signed = (r_op == MULDIV_OP_MULT) || (r_op == MULDIV_OP_MADD);
    assign w_ext_a      = {{32{w_mul_signed & r_a[31]}}, r_a};
    assign w_ext_b      = {{32{w_mul_signed & r_b[31]}}, r_b};
    assign w_prod       = w_ext_a * w_ext_b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= MULDIV_ST_IDLE;
            r_cnt   <= 6'd0;
            r_op    <= MULDIV_OP_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_dz    <= 1'b0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (i_flush) begin
            r_state <= MULDIV_ST_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            case (r_state)
                MULDIV_ST_IDLE: begin
                    if (i_start) begin
                        if (i_op == MULDIV_OP_MTHI) begin
                            r_hi <= i_op_a;
                        end else if (i_op == MULDIV_OP_MTLO) begin
                            r_lo <= i_op_a;
                        end else if (is_mul_op(i_op)) begin
                            r_op    <= i_op;
                            r_a     <= i_op_a;
                            r_b     <= i_op_b;
                            r_cnt   <= 6'd1;
                            r_state <= (MUL_LAT == 1) ? MULDIV_ST_DONE : MULDIV_ST_MUL;
                        end else if (is_div_op(i_op)) begin
                            r_op    <= i_op;
                            r_a     <= i_op_a;
                            r_b     <= i_op_b;
                            r_cnt   <= 6'd0;
                            r_dz    <= (i_op_b == 32'd0);
                            r_q_neg <= w_div_signed & (i_op_a[31] ^ i_op_b[31]);
                            r_r_neg <= w_div_signed & i_op_a[31];
                            r_state <= (i_op_b == 32'd0) ? MULDIV_ST_DONE : MULDIV_ST_DIV;
                        end
                    end
                end
                MULDIV_ST_MUL: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(MUL_LAT - 1)) begin
                        r_state <= MULDIV_ST_DONE;
                    end
                end
                MULDIV_ST_DIV: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (w_div_done) begin
                        r_state <= MULDIV_ST_DONE;
                    end
                end
                MULDIV_ST_DONE: begin
                    if (is_div_op(r_op)) begin
                        if (r_dz) begin
                            r_hi <= r_a;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                    end
`ifdef MULDIV_MADD_EN
                    else if (r_op == MULDIV_OP_MADD) begin
                        {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
                    end
`endif
                    else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_cnt   <= 6'd0;
                    r_state <= MULDIV_ST_IDLE;
                end
                default: r_state <= MULDIV_ST_IDLE;
            endcase
        end
    end

    assign o_stall = !i_rst && !i_flush &&
                     (((r_state == MULDIV_ST_IDLE) && i_start && (is_mul_op(i_op) || is_div_op(i_op)))
                      || (r_state == MULDIV_ST_MUL) || (r_state == MULDIV_ST_DIV));
    assign o_busy  = (r_state != MULDIV_ST_IDLE);
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases with literal results, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_muldiv_ctrl;

    localparam int MUL_LAT  = 2;
    localparam int DIV_ITER = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_op    (op),
        .i_op_a  (op_a),
        .i_op_b  (op_b),
        .i_flush (flush),
        .o_stall (stall),
        .o_busy  (busy),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model: architectural HI/LO plus one pending result with cycles left to its commit cycle.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_res_hi = 32'd0;
    logic [31:0] m_res_lo = 32'd0;
    bit          m_act = 1'b0;
    int          m_left = 0;
    logic [63:0] m_r;
    bit          exp_stall;

    bit          lit_chk = 1'b0;
    string       lit_name = "";
    logic [31:0] lit_hi = 32'd0;
    logic [31:0] lit_lo = 32'd0;
    logic        lit_stall = 1'b0;

    function automatic bit long_op(input logic [2:0] o);
        if (o >= 3'd1 && o <= 3'd4) return 1'b1;
`ifdef MULDIV_MADD_EN
        if (o == 3'd7) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int op_lat(input logic [2:0] o, input logic [31:0] b);
        if (o == 3'd3 || o == 3'd4) return (b == 32'd0) ? 1 : DIV_ITER + 1;
        return MUL_LAT;
    endfunction

    function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] acc);
        longint sa;
        longint sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1: r = 64'(sa * sb);
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            3'd4: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            3'd7: r = acc + 64'(sa * sb);
            default: r = acc;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_stall", {31'd0, stall}, 32'd0);
            chk("rst_busy",  {31'd0, busy},  32'd0);
            chk("rst_hi", hi, 32'd0);
            chk("rst_lo", lo, 32'd0);
            m_hi = 32'd0; m_lo = 32'd0; m_act = 1'b0; m_left = 0;
        end else begin
            if (flush)       exp_stall = 1'b0;
            else if (!m_act) exp_stall = start && long_op(op);
            else             exp_stall = (m_left > 0);
            chk("stall", {31'd0, stall}, {31'd0, exp_stall});
            chk("busy",  {31'd0, busy},  {31'd0, m_act});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            if (flush) begin
                m_act = 1'b0;
            end else if (!m_act) begin
                if (start) begin
                    if (op == 3'd5) m_hi = op_a;
                    else if (op == 3'd6) m_lo = op_a;
                    else if (long_op(op)) begin
                        m_r = model_result(op, op_a, op_b, {m_hi, m_lo});
                        m_res_hi = m_r[63:32];
                        m_res_lo = m_r[31:0];
                        m_act = 1'b1;
                        m_left = op_lat(op, op_b) - 1;
                    end
                end
            end else if (m_left == 0) begin
                m_hi = m_res_hi;
                m_lo = m_res_lo;
                m_act = 1'b0;
            end else begin
                m_left--;
            end
        end
        if (lit_chk) begin
            chk({lit_name, "_stall"}, {31'd0, stall}, {31'd0, lit_stall});
            chk({lit_name, "_hi"}, hi, lit_hi);
            chk({lit_name, "_lo"}, lo, lit_lo);
        end
    end

    task automatic drive(input bit st, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit fl);
        start = st; op = o; op_a = a; op_b = b; flush = fl;
        @(posedge clk);
        #1;
        lit_chk = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic expect_lit(input string nm, input logic [31:0] h, input logic [31:0] l,
                              input logic s);
        lit_name = nm; lit_hi = h; lit_lo = l; lit_stall = s; lit_chk = 1'b1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 rst = 1'b1;
        @(posedge clk); #1;
        expect_lit("reset", 32'd0, 32'd0, 1'b0);
        drive(1'b1, 3'd1, 32'd5, 32'd6, 1'b0);
        idle(1);
        rst = 1'b0;

        drive(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        expect_lit("mult_c1", 32'd0, 32'd0, 1'b1); idle(1);
        expect_lit("mult_c2", 32'd0, 32'd0, 1'b0); idle(1);
        idle(1);
        expect_lit("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0); idle(1);

        drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle(3);
        expect_lit("multu", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0); idle(1);

        drive(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(31);
        expect_lit("div_c32", 32'hFFFF_FFFE, 32'h0000_0001, 1'b1); idle(1);
        expect_lit("div_c33", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0); idle(1);
        expect_lit("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0); idle(1);

        drive(1'b1, 3'd4, 32'd100, 32'd7, 1'b0);
        idle(34);
        expect_lit("divu", 32'd2, 32'd14, 1'b0); idle(1);

        drive(1'b1, 3'd4, 32'h1234, 32'd0, 1'b0);
        expect_lit("dz_c1", 32'd2, 32'd14, 1'b0); idle(1);
        expect_lit("dz", 32'h1234, 32'hFFFF_FFFF, 1'b0); idle(1);

        drive(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(34);
        expect_lit("div_ovf", 32'd0, 32'h8000_0000, 1'b0); idle(1);

        drive(1'b1, 3'd5, 32'hAAAA, 32'd0, 1'b0);
        expect_lit("mthi", 32'hAAAA, 32'h8000_0000, 1'b0); idle(1);
        drive(1'b1, 3'd3, 32'd100, 32'd3, 1'b0);
        idle(9);
        expect_lit("flush", 32'hAAAA, 32'h8000_0000, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        drive(1'b1, 3'd1, 32'd5, 32'd6, 1'b0);
        idle(3);
        expect_lit("post_flush_mult", 32'd0, 32'd30, 1'b0); idle(1);
        drive(1'b1, 3'd5, 32'h1111, 32'd0, 1'b1);
        expect_lit("flush_mthi", 32'd0, 32'd30, 1'b0); idle(1);

        drive(1'b1, 3'd3, 32'd1000, 32'd7, 1'b0);
        idle(4);
        rst = 1'b1;
        #1;
        expect_lit("rst_mid", 32'd0, 32'd0, 1'b0); idle(2);
        rst = 1'b0;

        drive(1'b1, 3'd1, 32'd7, 32'd8, 1'b0);
        drive(1'b1, 3'd6, 32'h55, 32'd0, 1'b0);
        drive(1'b1, 3'd6, 32'h55, 32'd0, 1'b0);
        expect_lit("held_done", 32'd0, 32'd56, 1'b0); idle(1);
        drive(1'b1, 3'd6, 32'h55, 32'd0, 1'b0);
        expect_lit("mtlo", 32'd0, 32'h55, 1'b0); idle(1);

        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  r_o;
            logic [31:0] r_a;
            logic [31:0] r_b;
            r_o = 3'($urandom_range(0, 7));
            r_a = pick();
            r_b = pick();
            rst = ($urandom_range(0, 1999) == 0);
            drive($urandom_range(0, 3) == 0, r_o, r_a, r_b, $urandom_range(0, 63) == 0);
        end
        rst = 1'b0;
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
